mac_accum: RTL and testbench

MAC_ACCUM -- requirements
Module: mac_accum

---
 rtl/mac_accum.sv | 121 ++++++++++++
 tb/tb_mac_accum.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum.sv
// rtl/mac_accum.sv - batch multiply-accumulate: N 4x4 products summed with saturation, held until taken
// Two-stage pipeline (product register, saturating accumulator) sequenced by an IDLE/ACCUM/DRAIN/HOLD FSM.
module mac_accum #(
  parameter int N     = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       m,
  input  logic [3:0]       q,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0]       N_L     = 8'(N);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_batch_start;
  logic [7:0]       w_p;
  logic [7:0]       w_count_inc;
  logic [ACC_W:0]   w_sum;
  logic [7:0]       r_p;
  logic             r_p_v;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [7:0]       r_count;

  assign w_p         = {4'b0000, m} * {4'b0000, q};
  assign w_accept    = in_valid & in_ready;
  assign w_count_inc = r_count + 8'd1;
  // Carry out of the extra top bit flags a sum beyond the accumulator range.
  assign w_sum       = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, r_p};

  always_comb begin
    w_state_nxt   = r_state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    w_batch_start = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_batch_start = 1'b1;
          w_state_nxt   = (N_L == 8'd1) ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (w_count_inc == N_L)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Last product is still in stage 1 on the first DRAIN cycle.
        if (!r_p_v) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_p     <= 8'd0;
      r_p_v   <= 1'b0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_p_v   <= w_accept;
      if (w_accept) begin
        r_p <= w_p;
      end
      // A batch start never coincides with a pending product: HOLD always separates batches.
      if (w_batch_start) begin
        r_acc   <= '0;
        r_ovf   <= 1'b0;
        r_count <= 8'd1;
      end else begin
        if (w_accept) begin
          r_count <= w_count_inc;
        end
        if (r_p_v) begin
          if (w_sum[ACC_W]) begin
            r_acc <= ACC_MAX;
            r_ovf <= 1'b1;
          end else begin
            r_acc <= w_sum[ACC_W-1:0];
          end
        end
      end
    end
  end

  assign acc = (r_state == HOLD) ? r_acc : '0;
  assign ovf = (r_state == HOLD) ? r_ovf : 1'b0;

endmodule

// File: tb/tb_mac_accum.sv
// tb/tb_mac_accum.sv - scoreboard bench for mac_accum (default, ACC_W=8 and N=1 instances)
module tb_mac_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] m;
  logic [3:0] q;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic        of0, of1, of2;
  logic [11:0] acc0;
  logic [7:0]  acc1;
  logic [11:0] acc2;

  always #5 clk = ~clk;

  mac_accum u_dut_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .m(m), .q(q),
    .acc(acc0), .ovf(of0), .out_valid(ov0), .out_ready(out_ready)
  );

  mac_accum #(.N(4), .ACC_W(8)) u_dut_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .m(m), .q(q),
    .acc(acc1), .ovf(of1), .out_valid(ov1), .out_ready(out_ready)
  );

  mac_accum #(.N(1), .ACC_W(12)) u_dut_n1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .m(m), .q(q),
    .acc(acc2), .ovf(of2), .out_valid(ov2), .out_ready(out_ready)
  );

  int          sel = 0;
  logic        s_in_ready, s_out_valid, s_ovf;
  logic [15:0] s_acc;

  always_comb begin
    s_in_ready  = rdy0;
    s_out_valid = ov0;
    s_ovf       = of0;
    s_acc       = {4'h0, acc0};
    case (sel)
      1: begin s_in_ready = rdy1; s_out_valid = ov1; s_ovf = of1; s_acc = {8'h00, acc1}; end
      2: begin s_in_ready = rdy2; s_out_valid = ov2; s_ovf = of2; s_acc = {4'h0, acc2}; end
      default: ;
    endcase
  end

  typedef struct {
    int unsigned acc;
    int unsigned ovf;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned e_sum, e_ovf, e_max;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    e_sum = 0;
    e_ovf = 0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.acc = e_sum;
    e.ovf = e_ovf;
    sb.push_back(e);
    model_clear();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; m = 4'd0; q = 4'd0;
    step();
    rst = 1'b0;
    check({tag, "_rst_in_ready"}, s_in_ready, 1);
    check({tag, "_rst_out_valid"}, s_out_valid, 0);
    check({tag, "_rst_acc"}, s_acc, 0);
    check({tag, "_rst_ovf"}, s_ovf, 0);
    model_clear();
  endtask

  // Drives one pair through an accept edge and folds it into the model.
  task automatic send(input string tag, input int unsigned mm, input int unsigned qq);
    check({tag, "_in_ready"}, s_in_ready, 1);
    m = 4'(mm); q = 4'(qq); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    e_sum = e_sum + mm * qq;
    if (e_sum > e_max) begin
      e_sum = e_max;
      e_ovf = 1;
    end
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int   k = 0;
    while (!s_out_valid && k < 20) begin
      step();
      k++;
    end
    check({tag, "_out_valid"}, s_out_valid, 1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_acc"}, s_acc, e.acc);
      check({tag, "_ovf"}, s_ovf, e.ovf);
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_rel_out_valid"}, s_out_valid, 0);
    check({tag, "_rel_in_ready"}, s_in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "bench timeout");
  end

  initial begin
    int unsigned pm[4] = '{3, 15, 0, 2};
    int unsigned pq[4] = '{5, 15, 9, 7};

    // Back-to-back batch with exact latency checks.
    sel = 0; e_max = 4095;
    do_reset("t1");
    for (int i = 0; i < 4; i++) send("t1", pm[i], pq[i]);
    push_exp();
    check("t1_lat0_out_valid", s_out_valid, 0);
    check("t1_drain_acc", s_acc, 0);
    check("t1_drain_in_ready", s_in_ready, 0);
    step();
    check("t1_lat1_out_valid", s_out_valid, 0);
    step();
    check("t1_lat2_out_valid", s_out_valid, 1);
    wait_result("t1");
    release_result("t1");

    // Same pairs with 3-cycle gaps.
    do_reset("t2");
    for (int i = 0; i < 4; i++) begin
      send("t2", pm[i], pq[i]);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          step();
          check("t2_gap_in_ready", s_in_ready, 1);
        end
      end
    end
    push_exp();
    wait_result("t2");
    release_result("t2");

    // 8-bit accumulator saturation then a clean batch.
    sel = 1; e_max = 255;
    do_reset("t3");
    for (int i = 0; i < 4; i++) send("t3a", 15, 15);
    push_exp();
    wait_result("t3a");
    release_result("t3a");
    for (int i = 0; i < 4; i++) send("t3b", 1, 1);
    push_exp();
    wait_result("t3b");
    release_result("t3b");

    // Result held while out_ready is low; in_valid pulses ignored.
    sel = 0; e_max = 4095;
    do_reset("t4");
    for (int i = 0; i < 4; i++) send("t4", 1, 2);
    push_exp();
    wait_result("t4");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); m = 4'd7; q = 4'd7;
      step();
      check("t4_hold_acc", s_acc, 8);
      check("t4_hold_in_ready", s_in_ready, 0);
      check("t4_hold_out_valid", s_out_valid, 1);
    end
    in_valid = 1'b0;
    release_result("t4");
    for (int i = 0; i < 4; i++) send("t4b", 1, 1);
    push_exp();
    wait_result("t4b");
    release_result("t4b");

    // Reset mid-batch discards the partial sum.
    do_reset("t5");
    send("t5", 5, 5);
    send("t5", 5, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_mid_in_ready", s_in_ready, 1);
    check("t5_mid_out_valid", s_out_valid, 0);
    check("t5_mid_acc", s_acc, 0);
    model_clear();
    for (int i = 0; i < 4; i++) send("t5", 1, 1);
    push_exp();
    wait_result("t5");
    release_result("t5");

    // Single-product batches.
    sel = 2; e_max = 4095;
    do_reset("t6");
    send("t6", 9, 9);
    push_exp();
    check("t6_lat0_out_valid", s_out_valid, 0);
    step();
    check("t6_lat1_out_valid", s_out_valid, 0);
    step();
    check("t6_lat2_out_valid", s_out_valid, 1);
    wait_result("t6");
    release_result("t6");

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
